// File: rtl/mag_peak_detect.sv
// Moving-average smoother for a magnitude stream with hysteresis pulse detection
// and peak reporting. Define PEAK_HOLDOFF_EN to add a post-event holdoff state.
module mag_peak_detect #(
  parameter int WIDTH   = 10,
  parameter int LOG_WIN = 3,
  parameter int CNT_W   = 12,
  parameter int HOLDOFF = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_mag,
  input  logic [WIDTH-1:0] i_thr_hi,
  input  logic [WIDTH-1:0] i_thr_lo,
  output logic [WIDTH-1:0] o_avg,
  output logic             o_avg_valid,
  output logic             o_peak_valid,
  output logic [WIDTH-1:0] o_peak_mag,
  output logic [CNT_W-1:0] o_peak_pos,
  output logic             o_busy
);

  localparam int WIN   = 1 << LOG_WIN;
  localparam int SUM_W = WIDTH + LOG_WIN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (HOLDOFF < 1) begin : g_holdoff_check
    $error("HOLDOFF must be at least 1");
  end

  logic [WIDTH-1:0]   win_reg [WIN];
  logic [LOG_WIN-1:0] wp_reg;
  logic [SUM_W-1:0]   sum_reg;
  logic [SUM_W-1:0]   sum_next;

  // Oldest sample leaves the window as the new one enters; modular math never overflows.
  assign sum_next = sum_reg + SUM_W'(i_mag) - SUM_W'(win_reg[wp_reg]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < WIN; i++) win_reg[i] <= '0;
      wp_reg      <= '0;
      sum_reg     <= '0;
      o_avg       <= '0;
      o_avg_valid <= 1'b0;
    end else begin
      o_avg_valid <= i_valid;
      if (i_valid) begin
        win_reg[wp_reg] <= i_mag;
        wp_reg          <= wp_reg + 1'b1;
        sum_reg         <= sum_next;
        o_avg           <= sum_next[SUM_W-1:LOG_WIN];
      end
    end
  end

`ifdef PEAK_HOLDOFF_EN
  typedef enum logic [1:0] {S_IDLE, S_ABOVE, S_HOLD} state_t;
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
  logic [HOLD_W-1:0] hold_reg, hold_next;
`else
  typedef enum logic {S_IDLE, S_ABOVE} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] peak_reg, peak_next;
  logic [CNT_W-1:0] pos_reg, pos_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             event_next;
  logic [WIDTH-1:0] peak_mag_next;
  logic [CNT_W-1:0] peak_pos_next;

  assign cnt_inc = cnt_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    peak_next     = peak_reg;
    pos_next      = pos_reg;
    cnt_next      = cnt_reg;
    event_next    = 1'b0;
    peak_mag_next = o_peak_mag;
    peak_pos_next = o_peak_pos;
`ifdef PEAK_HOLDOFF_EN
    hold_next     = hold_reg;
`endif
    if (o_avg_valid) begin
      case (state_reg)
        S_IDLE: begin
          if (o_avg >= i_thr_hi) begin
            state_next = S_ABOVE;
            peak_next  = o_avg;
            pos_next   = '0;
            cnt_next   = '0;
          end
        end
        S_ABOVE: begin
          cnt_next = cnt_inc;
          // The exiting sample closes the pulse and is not a peak candidate.
          if ((o_avg < i_thr_lo) || (cnt_inc == CNT_MAX)) begin
            event_next    = 1'b1;
            peak_mag_next = peak_reg;
            peak_pos_next = pos_reg;
`ifdef PEAK_HOLDOFF_EN
            state_next    = S_HOLD;
            hold_next     = '0;
`else
            state_next    = S_IDLE;
`endif
          end else if (o_avg > peak_reg) begin
            peak_next = o_avg;
            pos_next  = cnt_inc;
          end
        end
`ifdef PEAK_HOLDOFF_EN
        S_HOLD: begin
          if (hold_reg == HOLD_LAST) state_next = S_IDLE;
          else                       hold_next  = hold_reg + 1'b1;
        end
`endif
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= S_IDLE;
      peak_reg     <= '0;
      pos_reg      <= '0;
      cnt_reg      <= '0;
      o_peak_valid <= 1'b0;
      o_peak_mag   <= '0;
      o_peak_pos   <= '0;
`ifdef PEAK_HOLDOFF_EN
      hold_reg     <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      peak_reg     <= peak_next;
      pos_reg      <= pos_next;
      cnt_reg      <= cnt_next;
      o_peak_valid <= event_next;
      o_peak_mag   <= peak_mag_next;
      o_peak_pos   <= peak_pos_next;
`ifdef PEAK_HOLDOFF_EN
      hold_reg     <= hold_next;
`endif
    end
  end

  assign o_busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mag_peak_detect.sv
// Self-checking bench for mag_peak_detect: directed and randomized streams compared
// against a window/pulse reference model; honours PEAK_HOLDOFF_EN if defined.
`timescale 1ns/1ps
module tb_mag_peak_detect;

  localparam int WIDTH   = 10;
  localparam int CNT_W   = 12;
  localparam int SAT_W   = 4;
  localparam int HOLDOFF = 64;
`ifdef PEAK_HOLDOFF_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] mag    = '0;
  logic [WIDTH-1:0] thr_hi = '0;
  logic [WIDTH-1:0] thr_lo = '0;
  logic [WIDTH-1:0] avg, peak_mag, s_avg, s_peak_mag;
  logic             avg_valid, peak_valid, busy;
  logic             s_avg_valid, s_peak_valid, s_busy;
  logic [CNT_W-1:0] peak_pos;
  logic [SAT_W-1:0] s_peak_pos;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int in_q[$], in_cyc_q[$];
  int avg_q[$], avg_cyc_q[$];
  int ev_mag_q[$], ev_pos_q[$], ev_cyc_q[$];
  int sev_mag_q[$], sev_pos_q[$], sev_cyc_q[$];
  int x_avg[$];
  int x_mag[$], x_pos[$], x_idx[$];
  int xs_mag[$], xs_pos[$], xs_idx[$];

  mag_peak_detect #(.WIDTH(WIDTH), .LOG_WIN(3), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mag(mag),
    .i_thr_hi(thr_hi), .i_thr_lo(thr_lo),
    .o_avg(avg), .o_avg_valid(avg_valid), .o_peak_valid(peak_valid),
    .o_peak_mag(peak_mag), .o_peak_pos(peak_pos), .o_busy(busy)
  );

  mag_peak_detect #(.WIDTH(WIDTH), .LOG_WIN(3), .CNT_W(SAT_W), .HOLDOFF(HOLDOFF)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mag(mag),
    .i_thr_hi(thr_hi), .i_thr_lo(thr_lo),
    .o_avg(s_avg), .o_avg_valid(s_avg_valid), .o_peak_valid(s_peak_valid),
    .o_peak_mag(s_peak_mag), .o_peak_pos(s_peak_pos), .o_busy(s_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (avg_valid) begin
        avg_q.push_back(int'(avg));
        avg_cyc_q.push_back(cyc);
      end
      if (peak_valid) begin
        ev_mag_q.push_back(int'(peak_mag));
        ev_pos_q.push_back(int'(peak_pos));
        ev_cyc_q.push_back(cyc);
        $display("event main: mag=%0d pos=%0d cyc=%0d", peak_mag, peak_pos, cyc);
      end
      if (s_peak_valid) begin
        sev_mag_q.push_back(int'(s_peak_mag));
        sev_pos_q.push_back(int'(s_peak_pos));
        sev_cyc_q.push_back(cyc);
        $display("event sat: mag=%0d pos=%0d cyc=%0d", s_peak_mag, s_peak_pos, cyc);
      end
    end
  end

  task automatic drive(input bit v, input int m);
    @(posedge clk);
    #1;
    valid = v;
    mag   = WIDTH'(m);
    if (v) begin
      in_q.push_back(m);
      in_cyc_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  task automatic clear_logs();
    in_q.delete(); in_cyc_q.delete(); avg_q.delete(); avg_cyc_q.delete();
    ev_mag_q.delete(); ev_pos_q.delete(); ev_cyc_q.delete();
    sev_mag_q.delete(); sev_pos_q.delete(); sev_cyc_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  // Reference: window average from input history, then pulses found as spans
  // [entry, exit) with the first maximum inside the span.
  task automatic run_model(input int hi, input int lo);
    int s, j, st, e, pk, cmax, n;
    x_avg.delete();
    x_mag.delete(); x_pos.delete(); x_idx.delete();
    xs_mag.delete(); xs_pos.delete(); xs_idx.delete();
    foreach (in_q[i]) begin
      s = 0;
      for (int k = 0; k < 8; k++) if (i - k >= 0) s += in_q[i - k];
      x_avg.push_back(s / 8);
    end
    n = x_avg.size();
    for (int d = 0; d < 2; d++) begin
      cmax = (d == 0) ? (1 << CNT_W) - 1 : (1 << SAT_W) - 1;
      j = 0;
      while (j < n) begin
        if (x_avg[j] < hi) begin
          j++;
          continue;
        end
        st = j;
        e  = -1;
        for (int k = st + 1; k < n; k++) begin
          if (x_avg[k] < lo || k - st == cmax) begin
            e = k;
            break;
          end
        end
        if (e < 0) break;
        pk = st;
        for (int k = st + 1; k < e; k++) if (x_avg[k] > x_avg[pk]) pk = k;
        if (d == 0) begin
          x_mag.push_back(x_avg[pk]); x_pos.push_back(pk - st); x_idx.push_back(e);
        end else begin
          xs_mag.push_back(x_avg[pk]); xs_pos.push_back(pk - st); xs_idx.push_back(e);
        end
        j = e + 1 + (HOLD_ON ? HOLDOFF : 0);
      end
    end
  endtask

  task automatic test_reset();
    int    got[6];
    string nm[6] = '{"avg", "avg_valid", "peak_valid", "peak_mag", "peak_pos", "busy"};
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = '{int'(avg), int'(avg_valid), int'(peak_valid), int'(peak_mag), int'(peak_pos), int'(busy)};
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== 0) begin
        bad++;
        $display("FAIL reset_%s got=%0d want=0", nm[i], got[i]);
      end
    end
    $display("reset: outputs checked");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_ramp();
    int want;
    thr_hi = 10'd1023;
    thr_lo = 10'd0;
    do_reset();
    repeat (12) drive(1'b1, 80);
    idle(3);
    total++;
    if (avg_q.size() != 12) begin
      bad++;
      $display("FAIL ramp_count got=%0d want=12", avg_q.size());
    end
    for (int i = 0; i < avg_q.size() && i < 12; i++) begin
      want = (i < 8) ? (i + 1) * 10 : 80;
      total++;
      if (avg_q[i] != want || avg_cyc_q[i] != in_cyc_q[i] + 1) begin
        bad++;
        $display("FAIL ramp_avg[%0d] got=%0d@%0d want=%0d@%0d", i, avg_q[i], avg_cyc_q[i], want, in_cyc_q[i] + 1);
      end else $display("ramp: avg[%0d]=%0d", i, avg_q[i]);
    end
    total++;
    if (ev_mag_q.size() != 0) begin
      bad++;
      $display("FAIL ramp_no_event got=%0d want=0", ev_mag_q.size());
    end
  endtask

  task automatic test_pulse();
    thr_hi = 10'd100;
    thr_lo = 10'd50;
    do_reset();
    repeat (4)  drive(1'b1, 0);
    repeat (8)  drive(1'b1, 200);
    repeat (12) drive(1'b1, 0);
    idle(4);
    run_model(100, 50);
    total++;
    if (avg_q.size() != x_avg.size()) begin
      bad++;
      $display("FAIL pulse_avg_count got=%0d want=%0d", avg_q.size(), x_avg.size());
    end
    for (int i = 0; i < avg_q.size() && i < x_avg.size(); i++) begin
      total++;
      if (avg_q[i] != x_avg[i] || avg_cyc_q[i] != in_cyc_q[i] + 1) begin
        bad++;
        $display("FAIL pulse_avg[%0d] got=%0d@%0d want=%0d@%0d", i, avg_q[i], avg_cyc_q[i], x_avg[i], in_cyc_q[i] + 1);
      end
    end
    total++;
    if (ev_mag_q.size() != 1) begin
      bad++;
      $display("FAIL pulse_events got=%0d want=1", ev_mag_q.size());
    end else begin
      total++;
      if (ev_mag_q[0] != 200) begin
        bad++;
        $display("FAIL pulse_mag got=%0d want=200", ev_mag_q[0]);
      end
      total++;
      if (ev_pos_q[0] != 4) begin
        bad++;
        $display("FAIL pulse_pos got=%0d want=4", ev_pos_q[0]);
      end
      total++;
      if (ev_cyc_q[0] != in_cyc_q[18] + 2) begin
        bad++;
        $display("FAIL pulse_latency got=%0d want=%0d", ev_cyc_q[0], in_cyc_q[18] + 2);
      end
      $display("pulse: mag=%0d pos=%0d", ev_mag_q[0], ev_pos_q[0]);
    end
  endtask

  task automatic test_holdoff();
    int want_n;
    thr_hi = 10'd100;
    thr_lo = 10'd50;
    do_reset();
    repeat (4)  drive(1'b1, 0);
    repeat (8)  drive(1'b1, 200);
    repeat (16) drive(1'b1, 0);
    repeat (8)  drive(1'b1, 200);
    repeat (12) drive(1'b1, 0);
    @(negedge clk);
    total++;
    if (busy !== HOLD_ON) begin
      bad++;
      $display("FAIL holdoff_busy got=%0b want=%0b", busy, HOLD_ON);
    end
    repeat (60) drive(1'b1, 0);
    repeat (8)  drive(1'b1, 200);
    repeat (12) drive(1'b1, 0);
    idle(4);
    run_model(100, 50);
    want_n = HOLD_ON ? 2 : 3;
    total++;
    if (ev_mag_q.size() != want_n || x_mag.size() != want_n) begin
      bad++;
      $display("FAIL holdoff_events got=%0d want=%0d", ev_mag_q.size(), want_n);
    end
    for (int i = 0; i < ev_mag_q.size() && i < x_mag.size(); i++) begin
      total++;
      if (ev_mag_q[i] != x_mag[i] || ev_pos_q[i] != x_pos[i] || ev_cyc_q[i] != in_cyc_q[x_idx[i]] + 2) begin
        bad++;
        $display("FAIL holdoff_event[%0d] got=%0d/%0d@%0d want=%0d/%0d@%0d", i, ev_mag_q[i], ev_pos_q[i],
                 ev_cyc_q[i], x_mag[i], x_pos[i], in_cyc_q[x_idx[i]] + 2);
      end else $display("holdoff: event %0d mag=%0d pos=%0d", i, ev_mag_q[i], ev_pos_q[i]);
    end
  endtask

  task automatic test_saturation();
    thr_hi = 10'd300;
    thr_lo = 10'd50;
    do_reset();
    repeat (40) drive(1'b1, 300);
    idle(4);
    run_model(300, 50);
    total++;
    if (sev_mag_q.size() != xs_mag.size() || sev_mag_q.size() == 0) begin
      bad++;
      $display("FAIL sat_events got=%0d want=%0d", sev_mag_q.size(), xs_mag.size());
    end
    if (sev_mag_q.size() > 0) begin
      total++;
      if (sev_mag_q[0] != 300 || sev_pos_q[0] != 0 || sev_cyc_q[0] != in_cyc_q[22] + 2) begin
        bad++;
        $display("FAIL sat_first got=%0d/%0d@%0d want=300/0@%0d", sev_mag_q[0], sev_pos_q[0],
                 sev_cyc_q[0], in_cyc_q[22] + 2);
      end else $display("sat: forced event mag=%0d pos=%0d", sev_mag_q[0], sev_pos_q[0]);
    end
    for (int i = 1; i < sev_mag_q.size() && i < xs_mag.size(); i++) begin
      total++;
      if (sev_mag_q[i] != xs_mag[i] || sev_pos_q[i] != xs_pos[i] || sev_cyc_q[i] != in_cyc_q[xs_idx[i]] + 2) begin
        bad++;
        $display("FAIL sat_event[%0d] got=%0d/%0d@%0d want=%0d/%0d", i, sev_mag_q[i], sev_pos_q[i],
                 sev_cyc_q[i], xs_mag[i], xs_pos[i]);
      end
    end
    total++;
    if (ev_mag_q.size() != 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL sat_wide_counter got=%0d/%0b want=0/1", ev_mag_q.size(), busy);
    end
  endtask

  task automatic test_reset_above();
    int    got[6];
    string nm[6] = '{"avg", "avg_valid", "peak_valid", "peak_mag", "peak_pos", "busy"};
    thr_hi = 10'd100;
    thr_lo = 10'd50;
    do_reset();
    repeat (4)  drive(1'b1, 0);
    repeat (8)  drive(1'b1, 200);
    repeat (HOLDOFF + 20) drive(1'b1, 0);
    repeat (6)  drive(1'b1, 200);
    #2;
    total++;
    if (peak_mag !== 10'd200 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstabove_pre got=%0d/%0b want=200/1", peak_mag, busy);
    end
    rst   = 1'b1;
    valid = 1'b0;
    #1;
    got = '{int'(avg), int'(avg_valid), int'(peak_valid), int'(peak_mag), int'(peak_pos), int'(busy)};
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== 0) begin
        bad++;
        $display("FAIL rstabove_%s got=%0d want=0", nm[i], got[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    repeat (12) drive(1'b1, 0);
    idle(4);
    @(negedge clk);
    total++;
    if (ev_mag_q.size() != 0 || peak_mag !== '0 || peak_pos !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstabove_post got=%0d/%0d/%0d/%0b want=0/0/0/0", ev_mag_q.size(), peak_mag, peak_pos, busy);
    end else $display("rstabove: pulse discarded");
  endtask

  task automatic test_random();
    int hi, lo;
    bit high;
    for (int r = 0; r < 3; r++) begin
      hi = $urandom_range(100, 300);
      lo = $urandom_range(20, hi + 40);
      thr_hi = WIDTH'(hi);
      thr_lo = WIDTH'(lo);
      do_reset();
      high = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 19) == 0) high = ~high;
        if ($urandom_range(0, 3) == 0) drive(1'b0, 0);
        drive(1'b1, high ? $urandom_range(150, 600) : $urandom_range(0, 80));
      end
      idle(4);
      run_model(hi, lo);
      total++;
      if (avg_q.size() != x_avg.size() || ev_mag_q.size() != x_mag.size() || sev_mag_q.size() != xs_mag.size()) begin
        bad++;
        $display("FAIL rand%0d_counts got=%0d/%0d/%0d want=%0d/%0d/%0d", r, avg_q.size(), ev_mag_q.size(),
                 sev_mag_q.size(), x_avg.size(), x_mag.size(), xs_mag.size());
      end
      for (int i = 0; i < avg_q.size() && i < x_avg.size(); i++) begin
        total++;
        if (avg_q[i] != x_avg[i] || avg_cyc_q[i] != in_cyc_q[i] + 1) begin
          bad++;
          $display("FAIL rand%0d_avg[%0d] got=%0d@%0d want=%0d@%0d", r, i, avg_q[i], avg_cyc_q[i], x_avg[i], in_cyc_q[i] + 1);
        end
      end
      for (int i = 0; i < ev_mag_q.size() && i < x_mag.size(); i++) begin
        total++;
        if (ev_mag_q[i] != x_mag[i] || ev_pos_q[i] != x_pos[i] || ev_cyc_q[i] != in_cyc_q[x_idx[i]] + 2) begin
          bad++;
          $display("FAIL rand%0d_event[%0d] got=%0d/%0d@%0d want=%0d/%0d@%0d", r, i, ev_mag_q[i], ev_pos_q[i],
                   ev_cyc_q[i], x_mag[i], x_pos[i], in_cyc_q[x_idx[i]] + 2);
        end
      end
      for (int i = 0; i < sev_mag_q.size() && i < xs_mag.size(); i++) begin
        total++;
        if (sev_mag_q[i] != xs_mag[i] || sev_pos_q[i] != xs_pos[i] || sev_cyc_q[i] != in_cyc_q[xs_idx[i]] + 2) begin
          bad++;
          $display("FAIL rand%0d_sat[%0d] got=%0d/%0d@%0d want=%0d/%0d@%0d", r, i, sev_mag_q[i], sev_pos_q[i],
                   sev_cyc_q[i], xs_mag[i], xs_pos[i], in_cyc_q[xs_idx[i]] + 2);
        end
      end
      $display("rand%0d: hi=%0d lo=%0d events=%0d sat_events=%0d", r, hi, lo, ev_mag_q.size(), sev_mag_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_pulse();
    test_holdoff();
    test_saturation();
    test_reset_above();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
